// File: rtl/gain_stage.sv
// gain_stage: slews a Q8.8 gain toward the IAGC target and scales both ADC channels (round, saturate).
// Optional macro GAIN_STAGE_SATCOUNT_EN adds o_satCount, a saturating count of clipped output samples.
module gain_stage #(
  parameter int unsigned                  AXIS_DATA_SIZE   = 32,
  parameter int unsigned                  SAMPLE_SIZE      = 14,
  parameter int unsigned                  QUOTIENT_SIZE    = 8,
  parameter int unsigned                  FRACTIONAL_SIZE  = 8,
  parameter int unsigned                  IAGC_STATUS_SIZE = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0]  RUN_STATUS       = IAGC_STATUS_SIZE'(3),
  parameter int unsigned                  RAMP_STEP        = 1,
  parameter int unsigned                  RAMP_DIVIDER     = 1000
) (
  input  logic                                   i_clock,
  input  logic                                   i_nReset,
  input  logic [IAGC_STATUS_SIZE-1:0]            i_iagcStatus,
  input  logic [QUOTIENT_SIZE-1:0]               i_quotient,
  input  logic [FRACTIONAL_SIZE-1:0]             i_fractional,
  input  logic                                   i_gainValid,
  input  logic [AXIS_DATA_SIZE-1:0]              i_data,
  input  logic                                   i_dataValid,
  output logic [AXIS_DATA_SIZE-1:0]              o_data,
  output logic                                   o_dataValid,
  output logic [QUOTIENT_SIZE+FRACTIONAL_SIZE-1:0] o_gain,
  output logic                                   o_gainSettled,
  output logic                                   o_saturated
`ifdef GAIN_STAGE_SATCOUNT_EN
  ,
  output logic [15:0]                            o_satCount
`endif
);

  localparam int unsigned GAIN_W = QUOTIENT_SIZE + FRACTIONAL_SIZE;
  localparam int unsigned HALF_W = AXIS_DATA_SIZE / 2;
  localparam int unsigned PROD_W = SAMPLE_SIZE + GAIN_W + 1;
  localparam int unsigned DIV_W  = (RAMP_DIVIDER > 1) ? $clog2(RAMP_DIVIDER) : 1;

  localparam logic [GAIN_W-1:0]        UNITY     = GAIN_W'(2 ** FRACTIONAL_SIZE);
  localparam logic [GAIN_W-1:0]        STEP      = GAIN_W'(RAMP_STEP);
  localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(RAMP_DIVIDER - 1);
  localparam logic signed [PROD_W-1:0] ROUND_ADD = PROD_W'(2 ** (FRACTIONAL_SIZE - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX   = PROD_W'(2 ** (SAMPLE_SIZE - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} state_e;

  state_e             state_q, state_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic [GAIN_W-1:0]  target_q, target_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               settled_q;

  logic               run;
  logic               div_wrap;
  logic               gain_below;
  logic [GAIN_W-1:0]  gap;

  assign run        = (i_iagcStatus == RUN_STATUS);
  assign div_wrap   = (div_q == DIV_LAST);
  assign gain_below = (target_q > gain_q);
  assign gap        = gain_below ? (target_q - gain_q) : (gain_q - target_q);

  // Gain FSM: state register
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q   <= IDLE;
      gain_q    <= UNITY;
      target_q  <= UNITY;
      div_q     <= '0;
      settled_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      target_q  <= target_d;
      div_q     <= div_d;
      settled_q <= (gain_d == target_d);
    end
  end

  // Gain FSM: next state; ramp states share one slew path that re-evaluates direction every cycle
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    target_d = target_q;
    div_d    = div_q;
    if (!run) begin
      state_d  = IDLE;
      gain_d   = UNITY;
      target_d = UNITY;
      div_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = HOLD;
        HOLD: begin
          if (i_gainValid) target_d = {i_quotient, i_fractional};
          if (target_q != gain_q) begin
            state_d = gain_below ? RAMP_UP : RAMP_DOWN;
            div_d   = '0;
          end
        end
        default: begin
          if (i_gainValid) target_d = {i_quotient, i_fractional};
          div_d = div_wrap ? '0 : div_q + DIV_W'(1);
          if (target_q == gain_q) begin
            state_d = HOLD;
          end else if (div_wrap && (gap <= STEP)) begin
            gain_d  = target_q;
            state_d = HOLD;
          end else begin
            if (div_wrap) gain_d = gain_below ? (gain_q + STEP) : (gain_q - STEP);
            state_d = gain_below ? RAMP_UP : RAMP_DOWN;
          end
        end
      endcase
    end
  end

  assign o_gain        = gain_q;
  assign o_gainSettled = settled_q;

  // Round half up, then clip to the signed sample range; MSB of the result is the clip flag.
  function automatic logic [SAMPLE_SIZE:0] round_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] rnd;
    rnd = (prod + ROUND_ADD) >>> FRACTIONAL_SIZE;
    if (rnd > SAT_MAX)      round_sat = {1'b1, SAT_MAX[SAMPLE_SIZE-1:0]};
    else if (rnd < SAT_MIN) round_sat = {1'b1, SAT_MIN[SAMPLE_SIZE-1:0]};
    else                    round_sat = {1'b0, rnd[SAMPLE_SIZE-1:0]};
  endfunction

  logic                          s1_valid_q;
  logic signed [SAMPLE_SIZE-1:0] s1_ch1_q, s1_ch2_q;
  logic [GAIN_W-1:0]             s1_gain_q;
  logic                          s2_valid_q;
  logic signed [PROD_W-1:0]      s2_p1_q, s2_p2_q;
  logic signed [PROD_W-1:0]      s2_p1_d, s2_p2_d;
  logic [SAMPLE_SIZE:0]          res1, res2;
  logic [AXIS_DATA_SIZE-1:0]     data_d;
  logic                          sat_d;
  logic                          unused_data_pad;

  assign unused_data_pad = ^{i_data[HALF_W-SAMPLE_SIZE-1:0], i_data[AXIS_DATA_SIZE-SAMPLE_SIZE-1:HALF_W]};

  assign s2_p1_d = PROD_W'(s1_ch1_q) * PROD_W'($signed({1'b0, s1_gain_q}));
  assign s2_p2_d = PROD_W'(s1_ch2_q) * PROD_W'($signed({1'b0, s1_gain_q}));
  assign res1    = round_sat(s2_p1_q);
  assign res2    = round_sat(s2_p2_q);
  assign sat_d   = s2_valid_q & (res1[SAMPLE_SIZE] | res2[SAMPLE_SIZE]);

  always_comb begin
    data_d = '0;
    data_d[AXIS_DATA_SIZE-1 -: SAMPLE_SIZE] = res1[SAMPLE_SIZE-1:0];
    data_d[HALF_W-1 -: SAMPLE_SIZE]         = res2[SAMPLE_SIZE-1:0];
  end

  // Three-stage datapath: capture with gain snapshot, multiply, round/saturate
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      s1_valid_q  <= 1'b0;
      s1_ch1_q    <= '0;
      s1_ch2_q    <= '0;
      s1_gain_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_p1_q     <= '0;
      s2_p2_q     <= '0;
      o_dataValid <= 1'b0;
      o_data      <= '0;
      o_saturated <= 1'b0;
    end else begin
      s1_valid_q <= i_dataValid;
      if (i_dataValid) begin
        s1_ch1_q  <= i_data[AXIS_DATA_SIZE-1 -: SAMPLE_SIZE];
        s1_ch2_q  <= i_data[HALF_W-1 -: SAMPLE_SIZE];
        s1_gain_q <= gain_q;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_p1_q <= s2_p1_d;
        s2_p2_q <= s2_p2_d;
      end
      o_dataValid <= s2_valid_q;
      o_saturated <= sat_d;
      if (s2_valid_q) o_data <= data_d;
    end
  end

`ifdef GAIN_STAGE_SATCOUNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset)                        sat_cnt_q <= '0;
    else if (state_q == IDLE)             sat_cnt_q <= '0;
    else if (sat_d && (sat_cnt_q != '1))  sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign o_satCount = sat_cnt_q;
`endif

endmodule

// File: doc/gain_stage.md
Name: gain_stage

Overview:
Closes the IAGC loop by applying the processor's Q8.8 gain to the ADC sample stream before it reaches the DAC. It is inserted between the ADC output (adc_data/adc_data_valid) and the DAC input. It takes processorQuotient/processorFractional plus the amplitude-detector update strobe, slews the applied gain toward the new target, and multiplies, rounds and saturates both channels. Outside the run status it is a unity-gain pass-through.

Parameters:
AXIS_DATA_SIZE, 32, width of input/output sample word (two 16-bit channel halves)
SAMPLE_SIZE, 14, signed sample width per channel; ch1 = data[31:18], ch2 = data[15:2]
QUOTIENT_SIZE, 8, integer bits of gain
FRACTIONAL_SIZE, 8, fractional bits of gain; unity = 1 << FRACTIONAL_SIZE
IAGC_STATUS_SIZE, 4, width of global FSM status
RUN_STATUS, 4'd3, status code in which gain control is active
RAMP_STEP, 1, gain LSBs added/subtracted per ramp tick (>=1)
RAMP_DIVIDER, 1000, clock cycles per ramp tick (>=1)

Ports:
i_clock  in  1  system clock (clock0, 100 MHz)
i_nReset  in  1  asynchronous active-low reset (clocksValid)
i_iagcStatus  in  IAGC_STATUS_SIZE  global FSM status
i_quotient  in  QUOTIENT_SIZE  target gain integer part
i_fractional  in  FRACTIONAL_SIZE  target gain fractional part
i_gainValid  in  1  one-cycle strobe; latch {i_quotient,i_fractional} as target
i_data  in  AXIS_DATA_SIZE  ADC sample word
i_dataValid  in  1  sample strobe
o_data  out  AXIS_DATA_SIZE  scaled sample word, same packing, data[17:16] and data[1:0] = 0
o_dataValid  out  1  output strobe
o_gain  out  QUOTIENT_SIZE+FRACTIONAL_SIZE  currently applied gain (Q8.8)
o_gainSettled  out  1  high when applied gain == target
o_saturated  out  1  pulses with o_dataValid when either channel clipped

Behaviour:
- Reset (async, i_nReset=0): state IDLE; gain = target = 0x0100; divider = 0; pipeline valids cleared. Outputs: o_data=0, o_dataValid=0, o_gain=0x0100, o_gainSettled=1, o_saturated=0.
- Gain FSM states: IDLE, HOLD, RAMP_UP, RAMP_DOWN.
- IDLE: entered whenever i_iagcStatus != RUN_STATUS, from any state, on the next edge. Gain and target are forced to 0x0100 and i_gainValid is ignored. Leaves to HOLD when status == RUN_STATUS.
- HOLD: on i_gainValid, target <= {i_quotient,i_fractional}. If new target > gain go to RAMP_UP, if < go to RAMP_DOWN (decided the cycle after the latch), if equal stay in HOLD. Divider resets to 0 on entry to a ramp state.
- RAMP_UP/RAMP_DOWN: divider counts 0..RAMP_DIVIDER-1 and wraps. On wrap, gain moves RAMP_STEP toward target. If |target - gain| <= RAMP_STEP, gain snaps to target and the FSM goes to HOLD.
- i_gainValid during a ramp re-targets. Direction is re-evaluated the next cycle and the divider is not reset. If the new target equals the current gain, go to HOLD.
- o_gainSettled = (gain == target). o_gain = gain register.
- Datapath, 3-stage pipeline with fixed latency of 3 cycles from i_dataValid to o_dataValid. No backpressure; one sample accepted per cycle.
  - S1: register both 14-bit signed samples and a snapshot of the current gain.
  - S2: signed 14 x unsigned 16 multiply to a 31-bit signed product per channel.
  - S3: add 2^(FRACTIONAL_SIZE-1), arithmetic shift right by FRACTIONAL_SIZE (round half up), then saturate to [-8192, 8191].
- o_saturated = OR over both channels of the clip flag, qualified by the S3 valid.
- Samples in flight when status leaves RUN complete with their captured gain; the pipeline is not flushed.
- Gain 0x0000 is legal and produces all-zero samples.

Optional Feature:
GAIN_STAGE_SATCOUNT_EN:
- Defined: adds port o_satCount (out, 16). It increments on every o_saturated pulse, saturates at 0xFFFF, clears to 0 on reset and while in IDLE, and is exported to the logger.
- Undefined: no port and no counter logic.

Test Plan:
- Status RUN, gain 0x0100, ch1=1000, ch2=-1000 -> 3 cycles later o_data ch1=1000, ch2=-1000, o_saturated=0.
- RAMP_DIVIDER=4, RAMP_STEP=1, i_gainValid with target 0x0200, ch1=1000 -> gain ramps 1 LSB per 4 cycles, o_gainSettled=0 until gain=0x0200 after 256 ticks (~1024 cycles), then o_data ch1=2000.
- Gain 0x0200, ch1=5000, ch2=-5000 -> ch1=8191, ch2=-8192, o_saturated=1; with the macro defined, o_satCount=1.
- Gain 0x0080, ch1=3, ch2=-3 -> ch1=2, ch2=-1 (rounding check).
- Mid-ramp status drops from RUN to 0 -> next edge gain=0x0100 and o_gainSettled=1; samples issued 1-2 cycles earlier still exit with the old gain.
- Assert i_nReset=0 mid-stream with o_dataValid high -> o_dataValid, o_data and o_saturated go to 0 immediately (asynchronously) and o_gain=0x0100.
